// File: rtl/lcd_timing_pkg.sv
// Shared types, panel profiles and encodings for the LCD timing generator.
package lcd_timing_pkg;

    localparam int PF_W   = 16;
    localparam int TOT_XW = 2;

    localparam int SYNC_DE_ONLY = 0;
    localparam int SYNC_HV      = 1;

    typedef struct packed {
        logic [PF_W-1:0] h_sync;
        logic [PF_W-1:0] h_back;
        logic [PF_W-1:0] h_disp;
        logic [PF_W-1:0] h_front;
        logic [PF_W-1:0] v_sync;
        logic [PF_W-1:0] v_back;
        logic [PF_W-1:0] v_disp;
        logic [PF_W-1:0] v_front;
    } lcd_timing_t;

    typedef enum logic [1:0] {
        PANEL_4342,
        PANEL_7084,
        PANEL_7016,
        PANEL_1018
    } lcd_panel_e;

    typedef enum logic {
        CFG_IDLE,
        CFG_PEND
    } cfg_state_e;

    localparam lcd_timing_t PROF_4342 = '{
        h_sync: 16'd41,  h_back: 16'd2,  h_disp: 16'd480,  h_front: 16'd2,
        v_sync: 16'd10,  v_back: 16'd2,  v_disp: 16'd272,  v_front: 16'd2
    };

    localparam lcd_timing_t PROF_7084 = '{
        h_sync: 16'd128, h_back: 16'd88, h_disp: 16'd800,  h_front: 16'd40,
        v_sync: 16'd2,   v_back: 16'd33, v_disp: 16'd480,  v_front: 16'd10
    };

    localparam lcd_timing_t PROF_7016 = '{
        h_sync: 16'd20,  h_back: 16'd140, h_disp: 16'd1024, h_front: 16'd160,
        v_sync: 16'd3,   v_back: 16'd20,  v_disp: 16'd600,  v_front: 16'd12
    };

    localparam lcd_timing_t PROF_1018 = '{
        h_sync: 16'd10,  h_back: 16'd80, h_disp: 16'd1280, h_front: 16'd70,
        v_sync: 16'd3,   v_back: 16'd10, v_disp: 16'd800,  v_front: 16'd10
    };

    localparam lcd_panel_e RESET_PANEL = PANEL_4342;

    function automatic lcd_timing_t panel_profile(input lcd_panel_e p);
        lcd_timing_t t;
        unique case (p)
            PANEL_7084: t = PROF_7084;
            PANEL_7016: t = PROF_7016;
            PANEL_1018: t = PROF_1018;
            default:    t = PROF_4342;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lcd_timing_gen_axis_cnt.sv
// One timing axis: counter with wrap plus sync, active and request window decode.
module lcd_axis_cnt
    import lcd_timing_pkg::*;
#(
    parameter int CNT_W = 12,
    parameter int LEAD  = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_step,
    input  logic [CNT_W-1:0] i_sync,
    input  logic [CNT_W-1:0] i_back,
    input  logic [CNT_W-1:0] i_disp,
    input  logic [CNT_W-1:0] i_front,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last,
    output logic             o_sync,
    output logic             o_act,
    output logic             o_req,
    output logic [CNT_W-1:0] o_pos
);

    localparam int SW = CNT_W + TOT_XW;

    logic [CNT_W-1:0] r_cnt;
    logic [SW-1:0]    w_total;
    logic [SW-1:0]    w_start;
    logic [SW-1:0]    w_stop;
    logic [SW-1:0]    w_cnt;
    logic [SW-1:0]    w_lead;

    assign w_total = SW'(i_sync) + SW'(i_back) + SW'(i_disp) + SW'(i_front);
    assign w_start = SW'(i_sync) + SW'(i_back);
    assign w_stop  = w_start + SW'(i_disp);
    assign w_cnt   = SW'(r_cnt);
    assign w_lead  = w_cnt + SW'(LEAD);

    // >= keeps the counter bounded even if it ever lands past the end
    assign o_last = (w_cnt >= w_total - SW'(1));
    assign o_sync = (w_cnt < SW'(i_sync));
    assign o_act  = (w_cnt >= w_start) && (w_cnt < w_stop);
    assign o_req  = (w_lead >= w_start) && (w_lead < w_stop);
    assign o_pos  = CNT_W'(w_lead - w_start);
    assign o_cnt  = r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_step) begin
            r_cnt <= o_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// Programmable RGB LCD timing generator with frame-aligned shadow config.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int CNT_W     = 12,
    parameter int REQ_LEAD  = 1,
    parameter int SYNC_MODE = SYNC_DE_ONLY,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0
) (
    input  logic             lcd_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_h_sync,
    input  logic [CNT_W-1:0] cfg_h_back,
    input  logic [CNT_W-1:0] cfg_h_disp,
    input  logic [CNT_W-1:0] cfg_h_front,
    input  logic [CNT_W-1:0] cfg_v_sync,
    input  logic [CNT_W-1:0] cfg_v_back,
    input  logic [CNT_W-1:0] cfg_v_disp,
    input  logic [CNT_W-1:0] cfg_v_front,
    output logic             cfg_busy,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             lcd_hs,
    output logic             lcd_vs,
    output logic             lcd_de,
    output logic             lcd_pclk,
    output logic             data_req,
    output logic [CNT_W-1:0] pixel_xpos,
    output logic [CNT_W-1:0] pixel_ypos,
    output logic             frame_start,
    output logic             line_start
);

    localparam int SW = CNT_W + TOT_XW;

    localparam logic HV      = (SYNC_MODE == SYNC_HV);
    localparam logic HS_ON   = (HS_POL != 0);
    localparam logic VS_ON   = (VS_POL != 0);
    localparam logic HS_IDLE = HV ? ~HS_ON : 1'b1;
    localparam logic VS_IDLE = HV ? ~VS_ON : 1'b1;

    localparam logic [SW-1:0] MAX_TOT = SW'({CNT_W{1'b1}});

    typedef struct packed {
        logic [CNT_W-1:0] h_sync;
        logic [CNT_W-1:0] h_back;
        logic [CNT_W-1:0] h_disp;
        logic [CNT_W-1:0] h_front;
        logic [CNT_W-1:0] v_sync;
        logic [CNT_W-1:0] v_back;
        logic [CNT_W-1:0] v_disp;
        logic [CNT_W-1:0] v_front;
    } cfg_t;

    localparam lcd_timing_t RST_PROF = panel_profile(RESET_PANEL);

    localparam cfg_t RST_CFG = '{
        h_sync:  CNT_W'(RST_PROF.h_sync),
        h_back:  CNT_W'(RST_PROF.h_back),
        h_disp:  CNT_W'(RST_PROF.h_disp),
        h_front: CNT_W'(RST_PROF.h_front),
        v_sync:  CNT_W'(RST_PROF.v_sync),
        v_back:  CNT_W'(RST_PROF.v_back),
        v_disp:  CNT_W'(RST_PROF.v_disp),
        v_front: CNT_W'(RST_PROF.v_front)
    };

    cfg_t          r_act;
    cfg_t          r_pend;
    cfg_t          w_in;
    logic [SW-1:0] w_in_htot;
    logic [SW-1:0] w_in_vtot;
    logic          w_in_ok;
    logic          w_capture;
    logic          w_apply;
    cfg_state_e    r_state;
    cfg_state_e    w_state_nxt;
    logic          r_ack;
    logic          r_err;

    assign w_in = '{
        h_sync:  cfg_h_sync,
        h_back:  cfg_h_back,
        h_disp:  cfg_h_disp,
        h_front: cfg_h_front,
        v_sync:  cfg_v_sync,
        v_back:  cfg_v_back,
        v_disp:  cfg_v_disp,
        v_front: cfg_v_front
    };

    assign w_in_htot = SW'(cfg_h_sync) + SW'(cfg_h_back)
                     + SW'(cfg_h_disp) + SW'(cfg_h_front);
    assign w_in_vtot = SW'(cfg_v_sync) + SW'(cfg_v_back)
                     + SW'(cfg_v_disp) + SW'(cfg_v_front);

    assign w_in_ok = (cfg_h_sync != '0) && (cfg_h_disp != '0)
                  && (cfg_v_sync != '0) && (cfg_v_disp != '0)
                  && (w_in_htot <= MAX_TOT) && (w_in_vtot <= MAX_TOT);

    assign w_capture = cfg_load & w_in_ok;

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_h_sync;
    logic             w_v_sync;
    logic             w_h_act;
    logic             w_v_act;
    logic             w_h_req;
    logic             w_v_req;
    logic [CNT_W-1:0] w_h_pos;
    logic [CNT_W-1:0] w_v_pos;
    logic             w_frame_last;

    assign w_frame_last = w_h_last & w_v_last;

    // pending set is applied on the last frame cycle, or at once when idle
    always_comb begin
        w_state_nxt = r_state;
        w_apply     = 1'b0;
        unique case (r_state)
            CFG_IDLE: begin
                if (w_capture) w_state_nxt = CFG_PEND;
            end
            CFG_PEND: begin
                w_apply = ~en | w_frame_last;
                if (w_apply && !w_capture) w_state_nxt = CFG_IDLE;
            end
        endcase
    end

    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= CFG_IDLE;
            r_act   <= RST_CFG;
            r_pend  <= RST_CFG;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_apply;
            r_err   <= cfg_load & ~w_in_ok;
            if (w_apply)   r_act  <= r_pend;
            if (w_capture) r_pend <= w_in;
        end
    end

    lcd_axis_cnt #(
        .CNT_W (CNT_W),
        .LEAD  (REQ_LEAD)
    ) u_h (
        .i_clk   (lcd_clk),
        .i_rst   (sys_rst),
        .i_clr   (~en),
        .i_step  (en),
        .i_sync  (r_act.h_sync),
        .i_back  (r_act.h_back),
        .i_disp  (r_act.h_disp),
        .i_front (r_act.h_front),
        .o_cnt   (w_h_cnt),
        .o_last  (w_h_last),
        .o_sync  (w_h_sync),
        .o_act   (w_h_act),
        .o_req   (w_h_req),
        .o_pos   (w_h_pos)
    );

    lcd_axis_cnt #(
        .CNT_W (CNT_W),
        .LEAD  (0)
    ) u_v (
        .i_clk   (lcd_clk),
        .i_rst   (sys_rst),
        .i_clr   (~en),
        .i_step  (en & w_h_last),
        .i_sync  (r_act.v_sync),
        .i_back  (r_act.v_back),
        .i_disp  (r_act.v_disp),
        .i_front (r_act.v_front),
        .o_cnt   (w_v_cnt),
        .o_last  (w_v_last),
        .o_sync  (w_v_sync),
        .o_act   (w_v_act),
        .o_req   (w_v_req),
        .o_pos   (w_v_pos)
    );

    logic             w_hs_nxt;
    logic             w_vs_nxt;
    logic             w_de_nxt;
    logic             w_req_nxt;
    logic [CNT_W-1:0] w_x_nxt;
    logic [CNT_W-1:0] w_y_nxt;
    logic             w_fs_nxt;
    logic             w_ls_nxt;

    always_comb begin
        w_hs_nxt  = HS_IDLE;
        w_vs_nxt  = VS_IDLE;
        w_de_nxt  = 1'b0;
        w_req_nxt = 1'b0;
        w_x_nxt   = '0;
        w_y_nxt   = '0;
        w_fs_nxt  = 1'b0;
        w_ls_nxt  = 1'b0;
        if (en) begin
            if (HV) begin
                w_hs_nxt = w_h_sync ? HS_ON : ~HS_ON;
                w_vs_nxt = w_v_sync ? VS_ON : ~VS_ON;
            end
            w_de_nxt  = w_h_act & w_v_act;
            w_req_nxt = w_h_req & w_v_req;
            if (w_req_nxt) begin
                w_x_nxt = w_h_pos;
                w_y_nxt = w_v_pos;
            end
            w_ls_nxt = (w_h_cnt == '0);
            w_fs_nxt = w_ls_nxt && (w_v_cnt == '0);
        end
    end

    logic             r_hs;
    logic             r_vs;
    logic             r_de;
    logic             r_req;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             r_fs;
    logic             r_ls;

    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_hs  <= HS_IDLE;
            r_vs  <= VS_IDLE;
            r_de  <= 1'b0;
            r_req <= 1'b0;
            r_x   <= '0;
            r_y   <= '0;
            r_fs  <= 1'b0;
            r_ls  <= 1'b0;
        end else begin
            r_hs  <= w_hs_nxt;
            r_vs  <= w_vs_nxt;
            r_de  <= w_de_nxt;
            r_req <= w_req_nxt;
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_fs  <= w_fs_nxt;
            r_ls  <= w_ls_nxt;
        end
    end

    assign lcd_pclk    = lcd_clk;
    assign lcd_hs      = r_hs;
    assign lcd_vs      = r_vs;
    assign lcd_de      = r_de;
    assign data_req    = r_req;
    assign pixel_xpos  = r_x;
    assign pixel_ypos  = r_y;
    assign frame_start = r_fs;
    assign line_start  = r_ls;
    assign cfg_busy    = (r_state == CFG_PEND);
    assign cfg_ack     = r_ack;
    assign cfg_err     = r_err;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench: frame-index reference model vs two DUT parameterisations.
module tb_lcd_timing_gen;

    localparam int W = 12;

    typedef struct packed {
        logic         hs;
        logic         vs;
        logic         de;
        logic         req;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         fs;
        logic         ls;
        logic         busy;
        logic         ack;
        logic         err;
    } obs_t;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         en   = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] f [8];

    logic         a_hs, a_vs, a_de, a_req, a_fs, a_ls;
    logic         a_busy, a_ack, a_err, a_pclk;
    logic [W-1:0] a_x, a_y;
    logic         b_hs, b_vs, b_de, b_req, b_fs, b_ls;
    logic         b_busy, b_ack, b_err, b_pclk;
    logic [W-1:0] b_x, b_y;

    obs_t a_obs, b_obs;
    assign a_obs = {a_hs, a_vs, a_de, a_req, a_x, a_y,
                    a_fs, a_ls, a_busy, a_ack, a_err};
    assign b_obs = {b_hs, b_vs, b_de, b_req, b_x, b_y,
                    b_fs, b_ls, b_busy, b_ack, b_err};

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    initial for (int i = 0; i < 8; i++) f[i] = '0;

    lcd_timing_gen #(
        .CNT_W(W), .REQ_LEAD(1), .SYNC_MODE(1), .HS_POL(0), .VS_POL(1)
    ) u_a (
        .lcd_clk(clk), .sys_rst(rst), .en(en), .cfg_load(load),
        .cfg_h_sync(f[0]), .cfg_h_back(f[1]),
        .cfg_h_disp(f[2]), .cfg_h_front(f[3]),
        .cfg_v_sync(f[4]), .cfg_v_back(f[5]),
        .cfg_v_disp(f[6]), .cfg_v_front(f[7]),
        .cfg_busy(a_busy), .cfg_ack(a_ack), .cfg_err(a_err),
        .lcd_hs(a_hs), .lcd_vs(a_vs), .lcd_de(a_de), .lcd_pclk(a_pclk),
        .data_req(a_req), .pixel_xpos(a_x), .pixel_ypos(a_y),
        .frame_start(a_fs), .line_start(a_ls)
    );

    lcd_timing_gen #(
        .CNT_W(W), .REQ_LEAD(3), .SYNC_MODE(0), .HS_POL(1), .VS_POL(0)
    ) u_b (
        .lcd_clk(clk), .sys_rst(rst), .en(en), .cfg_load(load),
        .cfg_h_sync(f[0]), .cfg_h_back(f[1]),
        .cfg_h_disp(f[2]), .cfg_h_front(f[3]),
        .cfg_v_sync(f[4]), .cfg_v_back(f[5]),
        .cfg_v_disp(f[6]), .cfg_v_front(f[7]),
        .cfg_busy(b_busy), .cfg_ack(b_ack), .cfg_err(b_err),
        .lcd_hs(b_hs), .lcd_vs(b_vs), .lcd_de(b_de), .lcd_pclk(b_pclk),
        .data_req(b_req), .pixel_xpos(b_x), .pixel_ypos(b_y),
        .frame_start(b_fs), .line_start(b_ls)
    );

    // ---------------- reference model ----------------
    int   rst_cfg [8] = '{41, 2, 480, 2, 10, 2, 272, 2};
    int   act [8];
    int   pend [8];
    bit   m_busy;
    int   m_p;
    obs_t qa [$];
    obs_t qb [$];

    function automatic bit cfg_ok(input int c [8]);
        return c[0] != 0 && c[2] != 0 && c[4] != 0 && c[6] != 0
            && (c[0] + c[1] + c[2] + c[3]) <= 4095
            && (c[4] + c[5] + c[6] + c[7]) <= 4095;
    endfunction

    function automatic obs_t expect_obs(input int lead, input bit hv,
                                        input bit hpol, input bit vpol,
                                        input bit on, input int h,
                                        input int v, input int c [8]);
        obs_t o;
        int   hst, vst;
        bit   vin;
        o   = '0;
        hst = c[0] + c[1];
        vst = c[4] + c[5];
        vin = (v >= vst) && (v < vst + c[6]);
        o.hs = hv ? ~hpol : 1'b1;
        o.vs = hv ? ~vpol : 1'b1;
        if (on) begin
            o.de  = (h >= hst) && (h < hst + c[2]) && vin;
            o.req = (h + lead >= hst) && (h + lead < hst + c[2]) && vin;
            if (o.req) begin
                o.x = W'(h + lead - hst);
                o.y = W'(v - vst);
            end
            o.ls = (h == 0);
            o.fs = (h == 0) && (v == 0);
            if (hv) begin
                o.hs = (h < c[0]) ? hpol : ~hpol;
                o.vs = (v < c[4]) ? vpol : ~vpol;
            end
        end
        return o;
    endfunction

    initial begin
        int   cin [8];
        int   ht, vt, h, v;
        bit   ack, err;
        obs_t ea, eb;
        forever begin
            @(posedge clk);
            if (rst) begin
                act    = rst_cfg;
                m_busy = 1'b0;
                m_p    = 0;
                ea = expect_obs(1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, act);
                eb = expect_obs(3, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, act);
            end else begin
                for (int i = 0; i < 8; i++) cin[i] = int'(f[i]);
                ht = act[0] + act[1] + act[2] + act[3];
                vt = act[4] + act[5] + act[6] + act[7];
                h  = m_p % ht;
                v  = m_p / ht;
                ea = expect_obs(1, 1'b1, 1'b0, 1'b1, en, h, v, act);
                eb = expect_obs(3, 1'b0, 1'b1, 1'b0, en, h, v, act);
                ack = m_busy && (!en || m_p == ht * vt - 1);
                err = load && !cfg_ok(cin);
                if (ack) begin
                    act    = pend;
                    m_busy = 1'b0;
                end
                if (load && !err) begin
                    pend   = cin;
                    m_busy = 1'b1;
                end
                m_p = en ? (m_p + 1) % (ht * vt) : 0;
                ea.ack = ack;  ea.err = err;  ea.busy = m_busy;
                eb.ack = ack;  eb.err = err;  eb.busy = m_busy;
            end
            qa.push_back(ea);
            qb.push_back(eb);
        end
    end

    // ---------------- monitor ----------------
    initial begin
        obs_t ea, eb;
        forever begin
            @(negedge clk);
            if (qa.size() > 0 && qb.size() > 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                n_chk++;
                if (a_obs !== ea) begin
                    n_err++;
                    $display("FAIL a_obs t=%0t got=%h expected=%h",
                             $time, a_obs, ea);
                end
                n_chk++;
                if (b_obs !== eb) begin
                    n_err++;
                    $display("FAIL b_obs t=%0t got=%h expected=%h",
                             $time, b_obs, eb);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic load_cfg(input int c [8]);
        for (int i = 0; i < 8; i++) f[i] = W'(c[i]);
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic rand_cfg(output int c [8]);
        c[0] = int'($urandom_range(1, 4));
        c[1] = int'($urandom_range(0, 3));
        c[2] = int'($urandom_range(1, 5));
        c[3] = int'($urandom_range(0, 3));
        c[4] = int'($urandom_range(1, 2));
        c[5] = int'($urandom_range(0, 2));
        c[6] = int'($urandom_range(1, 3));
        c[7] = int'($urandom_range(0, 2));
        case ($urandom_range(0, 7))
            0: c[2] = 0;
            1: c[4] = 0;
            2: c[3] = 4095;
            3: c[7] = 4094;
            default: ;
        endcase
    endtask

    task automatic measure_frame(input string name, input int exp_per,
                                 input int exp_de);
        int guard, per, des;
        guard = 0;
        while (a_fs !== 1'b1 && guard < 400) begin
            step();
            guard++;
        end
        per = 0;
        des = 0;
        do begin
            if (a_de === 1'b1) des++;
            per++;
            step();
        end while (a_fs !== 1'b1 && per < 400);
        chk({name, "_period"}, per, exp_per);
        chk({name, "_de_cycles"}, des, exp_de);
    endtask

    int c_base  [8] = '{2, 3, 4, 1, 1, 1, 2, 1};
    int c_wide  [8] = '{2, 3, 6, 1, 1, 1, 2, 1};
    int c_tall  [8] = '{2, 3, 6, 1, 1, 1, 3, 1};
    int c_vzero [8] = '{2, 3, 4, 1, 1, 1, 0, 1};
    int c_ovf   [8] = '{4000, 100, 1, 1, 1, 1, 2, 1};

    initial begin
        int c [8];
        step(3);
        chk("rst_a_hs", int'(a_hs), 1);
        chk("rst_a_vs", int'(a_vs), 0);
        chk("rst_b_hs", int'(b_hs), 1);
        chk("rst_busy", int'(a_busy), 0);
        rst = 1'b0;

        load_cfg(c_base);
        step(2);
        en = 1'b1;
        step(5);
        measure_frame("base", 50, 8);

        step(int'($urandom_range(0, 30)));
        load_cfg(c_wide);
        chk("busy_after_load", int'(a_busy), 1);
        step(70);
        measure_frame("wide", 60, 12);

        load_cfg(c_vzero);
        chk("err_vzero", int'(a_err), 1);
        chk("busy_vzero", int'(a_busy), 0);
        step(10);
        load_cfg(c_ovf);
        chk("err_ovf", int'(a_err), 1);
        step(10);

        load_cfg(c_base);
        step(3);
        load_cfg(c_tall);
        step(150);
        measure_frame("tall", 72, 18);

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                rand_cfg(c);
                for (int i = 0; i < 8; i++) f[i] = W'(c[i]);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 149) == 0) en = ~en;
            step();
        end
        load = 1'b0;

        load_cfg(c_base);
        en = 1'b1;
        step(60 + int'($urandom_range(0, 7)));
        rst = 1'b1;
        step();
        chk("rst_mid_de", int'(a_de), 0);
        chk("rst_mid_x", int'(b_x), 0);
        chk("rst_mid_busy", int'(a_busy), 0);
        rst = 1'b0;
        en  = 1'b0;
        step(2);
        en = 1'b1;
        step();
        chk("fs_after_rst", int'(a_fs), 1);
        step(40);

        chk("pclk_low", int'(a_pclk), 0);
        #5;
        chk("pclk_high", int'(b_pclk), 1);
        step(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
